or_fifo_dut: RTL and testbench

- Register-mapped 1-bit OR engine.
- A host writes operand bits into two input FIFOs (A, B) over a simple write port.
- The block pops one bit from each FIFO, pushes A|B into an output FIFO (Y), and the host reads status and results over a read port.
- Sits behind the CLK/RST_N bench wrapper as the sole datapath block.

---
 rtl/or_fifo_dut_if.sv | 25 ++
 rtl/or_fifo_dut.sv | 110 +++++++++++
 tb/tb_or_fifo_dut.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/or_fifo_dut_if.sv
// Host-side register bus for or_fifo_dut.
//   write_address/write_data/write_en : register write port (host -> block)
//   write_rdy                          : write port ready (block -> host)
//   read_address/read_en               : register read select and strobe (host -> block)
//   read_data/read_rdy                 : read value and read port ready (block -> host)
interface or_fifo_dut_if;
  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy;
  logic [2:0] read_address;
  logic       read_en;
  logic       read_data;
  logic       read_rdy;

  modport master (
    output write_address, write_data, write_en, read_address, read_en,
    input  write_rdy, read_data, read_rdy
  );

  modport slave (
    input  write_address, write_data, write_en, read_address, read_en,
    output write_rdy, read_data, read_rdy
  );
endinterface

// File: rtl/or_fifo_dut.sv
// Register-mapped 1-bit OR engine.
// Two operand FIFOs (A, B) are filled by host writes; whenever both hold data
// and the result FIFO (Y) has room, one bit is popped from each and A|B is
// pushed into Y. The host reads status and pops results over the read port.
//   CLK   : single clock, rising edge
//   RST_N : asynchronous active-low reset, empties all FIFOs
//   bus   : or_fifo_dut_if.slave register bus

// Circular 1-bit FIFO. Callers must not push when full or pop when empty.
module or_fifo_buf #(
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic          mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem    <= '{default: 1'b0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

module or_fifo_dut #(
  parameter int A_DEPTH = 2,
  parameter int B_DEPTH = 2,
  parameter int Y_DEPTH = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  or_fifo_dut_if.slave  bus
);
  logic a_head, a_empty, a_full;
  logic b_head, b_empty, b_full;
  logic y_head, y_empty, y_full;
  logic a_push, b_push, y_pop, compute;

  // All conditions use start-of-cycle flags, so a Y pop never frees room for
  // a compute in the same cycle, and a full input FIFO drops a host write even
  // if the compute pops it in that cycle.
  assign compute = !a_empty && !b_empty && !y_full;
  assign a_push  = bus.write_en && (bus.write_address == 3'd4) && !a_full;
  assign b_push  = bus.write_en && (bus.write_address == 3'd5) && !b_full;
  assign y_pop   = bus.read_en  && (bus.read_address  == 3'd3) && !y_empty;

  or_fifo_buf #(.DEPTH(A_DEPTH)) u_fifo_a (
    .CLK(CLK), .RST_N(RST_N), .push(a_push), .push_data(bus.write_data),
    .pop(compute), .head(a_head), .empty(a_empty), .full(a_full)
  );

  or_fifo_buf #(.DEPTH(B_DEPTH)) u_fifo_b (
    .CLK(CLK), .RST_N(RST_N), .push(b_push), .push_data(bus.write_data),
    .pop(compute), .head(b_head), .empty(b_empty), .full(b_full)
  );

  or_fifo_buf #(.DEPTH(Y_DEPTH)) u_fifo_y (
    .CLK(CLK), .RST_N(RST_N), .push(compute), .push_data(a_head | b_head),
    .pop(y_pop), .head(y_head), .empty(y_empty), .full(y_full)
  );

  always_comb begin
    bus.read_data = 1'b0;
    case (bus.read_address)
      3'd0:    bus.read_data = !a_full;
      3'd1:    bus.read_data = !b_full;
      3'd2:    bus.read_data = !y_empty;
      3'd3:    bus.read_data = y_head && !y_empty;
      default: bus.read_data = 1'b0;
    endcase
  end

  assign bus.write_rdy = 1'b1;
  assign bus.read_rdy  = 1'b1;
endmodule

// File: tb/tb_or_fifo_dut.sv
// Directed bench for or_fifo_dut: read-map and truth-table vectors from
// tables, plus hand-written sequences for fill, backpressure and mid-stream reset.
module tb_or_fifo_dut;
  logic CLK;
  logic RST_N;
  int   total;
  int   bad;

  or_fifo_dut_if bus ();

  or_fifo_dut #(.A_DEPTH(2), .B_DEPTH(2), .Y_DEPTH(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] addr;
    logic       exp;
  } rd_vec_t;

  typedef struct {
    logic a;
    logic b;
    logic y;
  } tt_vec_t;

  rd_vec_t rd_tab [8];
  tt_vec_t tt_tab [4];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic [2:0] addr, input logic exp);
    bus.read_address = addr;
    #1;
    chk(name, bus.read_data, exp);
  endtask

  task automatic wr(input logic [2:0] addr, input logic d);
    bus.write_address = addr;
    bus.write_data    = d;
    bus.write_en      = 1'b1;
    tick();
    bus.write_en      = 1'b0;
  endtask

  task automatic pop_y;
    bus.read_address = 3'd3;
    bus.read_en      = 1'b1;
    tick();
    bus.read_en      = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rd_tab = '{'{3'd0, 1'b1}, '{3'd1, 1'b1}, '{3'd2, 1'b0}, '{3'd3, 1'b0},
               '{3'd4, 1'b0}, '{3'd5, 1'b0}, '{3'd6, 1'b0}, '{3'd7, 1'b0}};
    tt_tab = '{'{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1},
               '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1}};

    RST_N             = 1'b0;
    bus.write_address = 3'd0;
    bus.write_data    = 1'b0;
    bus.write_en      = 1'b0;
    bus.read_address  = 3'd0;
    bus.read_en       = 1'b0;
    tick();
    chk_rd("in_reset_y_status", 3'd2, 1'b0);
    chk("in_reset_write_rdy", bus.write_rdy, 1'b1);
    tick();
    RST_N = 1'b1;
    tick();

    // Reset read map
    for (int i = 0; i < 8; i++) begin
      chk_rd($sformatf("reset_addr%0d", rd_tab[i].addr), rd_tab[i].addr, rd_tab[i].exp);
      tick();
    end
    chk("write_rdy", bus.write_rdy, 1'b1);
    chk("read_rdy", bus.read_rdy, 1'b1);

    // Writes to unmapped addresses must not create operands
    wr(3'd0, 1'b1);
    wr(3'd6, 1'b1);
    wr(3'd5, 1'b1);
    tick();
    chk_rd("ignored_addr_no_result", 3'd2, 1'b0);
    wr(3'd4, 1'b0);
    tick();
    chk_rd("after_pair_result", 3'd2, 1'b1);
    pop_y();

    // Basic: A=1, B=0 -> 1
    wr(3'd4, 1'b1);
    wr(3'd5, 1'b0);
    tick();
    chk_rd("basic_y_status", 3'd2, 1'b1);
    chk_rd("basic_y_output", 3'd3, 1'b1);
    chk_rd("basic_addr7_zero", 3'd7, 1'b0);
    pop_y();
    chk_rd("basic_y_status_after_pop", 3'd2, 1'b0);
    chk_rd("basic_y_output_after_pop", 3'd3, 1'b0);

    // Truth table
    for (int i = 0; i < 4; i++) begin
      wr(3'd4, tt_tab[i].a);
      wr(3'd5, tt_tab[i].b);
      tick();
      chk_rd($sformatf("tt%0d_status", i), 3'd2, 1'b1);
      chk_rd($sformatf("tt%0d_output", i), 3'd3, tt_tab[i].y);
      pop_y();
      chk_rd($sformatf("tt%0d_drained", i), 3'd2, 1'b0);
    end

    // Fill A, overflow drop, then B back-to-back
    wr(3'd4, 1'b1);
    chk_rd("fill_a_one_entry", 3'd0, 1'b1);
    wr(3'd4, 1'b0);
    chk_rd("fill_a_full", 3'd0, 1'b0);
    wr(3'd4, 1'b1);
    chk_rd("fill_a_still_full", 3'd0, 1'b0);
    wr(3'd5, 1'b0);
    wr(3'd5, 1'b0);
    wr(3'd5, 1'b0);
    chk_rd("fill_b_full", 3'd1, 1'b0);
    chk_rd("fill_a_one_left", 3'd0, 1'b1);
    chk_rd("fill_res1", 3'd3, 1'b1);
    pop_y();
    tick();
    chk_rd("fill_res2_status", 3'd2, 1'b1);
    chk_rd("fill_res2", 3'd3, 1'b0);
    pop_y();
    tick();
    tick();
    chk_rd("fill_no_third", 3'd2, 1'b0);
    chk_rd("fill_b_left_not_full", 3'd1, 1'b1);
    // Flush the leftover B with a 0 operand
    wr(3'd4, 1'b0);
    tick();
    pop_y();

    // Y backpressure, no bypass
    wr(3'd4, 1'b0);
    wr(3'd5, 1'b1);
    wr(3'd4, 1'b0);
    wr(3'd5, 1'b0);
    tick();
    chk_rd("bp_first", 3'd3, 1'b1);
    chk_rd("bp_a_not_full", 3'd0, 1'b1);
    chk_rd("bp_b_not_full", 3'd1, 1'b1);
    pop_y();
    chk_rd("bp_no_bypass", 3'd2, 1'b0);
    tick();
    chk_rd("bp_second_status", 3'd2, 1'b1);
    chk_rd("bp_second", 3'd3, 1'b0);
    pop_y();

    // Mid-stream reset with data in all FIFOs
    wr(3'd4, 1'b1);
    wr(3'd5, 1'b1);
    wr(3'd4, 1'b1);
    wr(3'd4, 1'b1);
    wr(3'd5, 1'b1);
    chk_rd("pre_rst_a_full", 3'd0, 1'b0);
    chk_rd("pre_rst_y", 3'd2, 1'b1);
    RST_N = 1'b0;
    chk_rd("rst_a_status", 3'd0, 1'b1);
    chk_rd("rst_b_status", 3'd1, 1'b1);
    chk_rd("rst_y_status", 3'd2, 1'b0);
    chk_rd("rst_y_output", 3'd3, 1'b0);
    tick();
    RST_N = 1'b1;
    tick();
    wr(3'd4, 1'b0);
    wr(3'd5, 1'b1);
    tick();
    chk_rd("post_rst_status", 3'd2, 1'b1);
    chk_rd("post_rst_output", 3'd3, 1'b1);
    pop_y();
    chk_rd("post_rst_drained", 3'd2, 1'b0);
    chk_rd("post_rst_a_status", 3'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
